// File: rtl/sd_block_bridge.sv
// Single-block transfer bridge between the host I/O bus and the sdCardCtrl byte handshake.
// Holds one read and one write buffer; sequences the command strobe, byte handshake and error reporting.
module sd_block_bridge #(
    parameter int BLOCK_BYTES = 512,
    parameter int BA_W        = $clog2(BLOCK_BYTES),
    parameter int LBA_W       = 32,
    parameter int TIMEOUT     = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_rd,
    input  logic             cmd_wr,
    input  logic [LBA_W-1:0] lba_i,
    output logic             ready,
    output logic             done,
    output logic [1:0]       err,
    input  logic [BA_W-1:0]  rbuf_addr,
    output logic [7:0]       rbuf_data,
    input  logic [BA_W-1:0]  wbuf_addr,
    input  logic [7:0]       wbuf_data,
    input  logic             wbuf_we,
    output logic [LBA_W-1:0] addr_o,
    output logic             rd_o,
    output logic             wr_o,
    input  logic             busy_i,
    input  logic             hndshk_i,
    output logic             hndshk_o,
    input  logic [7:0]       data_i,
    output logic [7:0]       data_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
    localparam logic [BA_W:0] BLK     = (BA_W + 1)'(BLOCK_BYTES);
    localparam logic [BA_W:0] BLK_SAT = (BA_W + 1)'(BLOCK_BYTES + 1);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_TMO   = 2'd1;
    localparam logic [1:0] ERR_SHORT = 2'd2;
    localparam logic [1:0] ERR_LONG  = 2'd3;

    typedef enum logic [2:0] {IDLE, START, XFER, HND, DONE} state_t;

    state_t             state, state_n;
    logic               dir_wr, dir_wr_n;
    logic [BA_W:0]      byte_cnt, byte_cnt_n;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
    logic [1:0]         err_n;
    logic [LBA_W-1:0]   addr_n;
    logic               rd_n, wr_n, hs_n;
    logic [7:0]         dout_n;
    logic               rbuf_we;
    logic               in_blk;
    logic [BA_W-1:0]    idx;

    logic [7:0] rbuf [BLOCK_BYTES];
    logic [7:0] wbuf [BLOCK_BYTES];

    assign idx       = byte_cnt[BA_W-1:0];
    assign in_blk    = (byte_cnt < BLK);
    assign rbuf_data = rbuf[rbuf_addr];

    always_comb begin
        state_n    = state;
        dir_wr_n   = dir_wr;
        byte_cnt_n = byte_cnt;
        tmo_cnt_n  = tmo_cnt;
        err_n      = err;
        addr_n     = addr_o;
        rd_n       = rd_o;
        wr_n       = wr_o;
        hs_n       = hndshk_o;
        dout_n     = data_o;
        rbuf_we    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_rd || cmd_wr) begin
                    addr_n     = lba_i;
                    dir_wr_n   = !cmd_rd;
                    err_n      = ERR_NONE;
                    byte_cnt_n = '0;
                    tmo_cnt_n  = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (busy_i) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = XFER;
                end else if (tmo_cnt == TMO_MAX) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    err_n   = ERR_TMO;
                    state_n = DONE;
                end else begin
                    rd_n      = !dir_wr;
                    wr_n      = dir_wr;
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            XFER: begin
                if (!busy_i) begin
                    if (in_blk && err == ERR_NONE)
                        err_n = ERR_SHORT;
                    state_n = DONE;
                end else if (hndshk_i) begin
                    if (dir_wr)
                        dout_n = in_blk ? wbuf[idx] : 8'h00;
                    else
                        rbuf_we = in_blk;
                    // Bytes past the block are still handshaked so the controller can drain.
                    if (!in_blk && err == ERR_NONE)
                        err_n = ERR_LONG;
                    if (byte_cnt != BLK_SAT)
                        byte_cnt_n = byte_cnt + 1'b1;
                    hs_n    = 1'b1;
                    state_n = HND;
                end
            end
            HND: begin
                if (!hndshk_i) begin
                    hs_n    = 1'b0;
                    state_n = XFER;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dir_wr   <= 1'b0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            err      <= ERR_NONE;
            addr_o   <= '0;
            rd_o     <= 1'b0;
            wr_o     <= 1'b0;
            hndshk_o <= 1'b0;
            data_o   <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            dir_wr   <= dir_wr_n;
            byte_cnt <= byte_cnt_n;
            tmo_cnt  <= tmo_cnt_n;
            err      <= err_n;
            addr_o   <= addr_n;
            rd_o     <= rd_n;
            wr_o     <= wr_n;
            hndshk_o <= hs_n;
            data_o   <= dout_n;
            ready    <= (state == IDLE);
            done     <= (state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rbuf_we)
            rbuf[idx] <= data_i;
        if (wbuf_we && !(dir_wr && (state inside {START, XFER, HND})))
            wbuf[wbuf_addr] <= wbuf_data;
    end

endmodule

// File: tb/tb_sd_block_bridge.sv
// Directed bench for sd_block_bridge with BLOCK_BYTES=4, TIMEOUT=20 and an inline controller model.
module tb_sd_block_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_rd, cmd_wr;
    logic [31:0] lba_i;
    logic        ready, done;
    logic [1:0]  err;
    logic [1:0]  rbuf_addr;
    logic [7:0]  rbuf_data;
    logic [1:0]  wbuf_addr;
    logic [7:0]  wbuf_data;
    logic        wbuf_we;
    logic [31:0] addr_o;
    logic        rd_o, wr_o;
    logic        busy_i, hndshk_i, hndshk_o;
    logic [7:0]  data_i, data_o;

    int errors = 0;
    int checks = 0;

    sd_block_bridge #(.BLOCK_BYTES(4), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr), .lba_i(lba_i),
        .ready(ready), .done(done), .err(err),
        .rbuf_addr(rbuf_addr), .rbuf_data(rbuf_data),
        .wbuf_addr(wbuf_addr), .wbuf_data(wbuf_data), .wbuf_we(wbuf_we),
        .addr_o(addr_o), .rd_o(rd_o), .wr_o(wr_o),
        .busy_i(busy_i), .hndshk_i(hndshk_i), .hndshk_o(hndshk_o),
        .data_i(data_i), .data_o(data_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input string tag, input logic rd, input logic [31:0] lba);
        @(negedge clk);
        cmd_rd = rd; cmd_wr = !rd; lba_i = lba;
        @(negedge clk);
        cmd_rd = 1'b0; cmd_wr = 1'b0; lba_i = '0;
        @(negedge clk);
        check({tag, "_strobe"}, rd ? rd_o : wr_o, 1);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_addr"}, addr_o, lba);
    endtask

    task automatic busy_on(input string tag);
        busy_i = 1'b1;
        @(negedge clk);
        check({tag, "_strobe_drop"}, {rd_o, wr_o}, 0);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] d, output logic [7:0] got);
        int n;
        data_i = d; hndshk_i = 1'b1; n = 0;
        @(negedge clk);
        while (!hndshk_o && n < 10) begin @(negedge clk); n++; end
        check({tag, "_hs_rise"}, hndshk_o, 1);
        got = data_o;
        hndshk_i = 1'b0; n = 0;
        @(negedge clk);
        while (hndshk_o && n < 10) begin @(negedge clk); n++; end
        check({tag, "_hs_fall"}, hndshk_o, 0);
    endtask

    task automatic finish_op(input string tag, input int exp_lat, input logic [1:0] exp_err);
        int lat;
        busy_i = 1'b0; lat = 0;
        do begin @(negedge clk); lat++; end while (!done && lat < 40);
        check({tag, "_done_lat"}, lat, exp_lat);
        check({tag, "_err"}, err, exp_err);
        @(negedge clk);
        check({tag, "_done_clr"}, done, 0);
        check({tag, "_ready"}, ready, 1);
    endtask

    task automatic check_rbuf(input string tag, input logic [31:0] e);
        for (int i = 0; i < 4; i++) begin
            rbuf_addr = 2'(i);
            #1;
            check($sformatf("%s_rbuf%0d", tag, i), rbuf_data, e[8*i +: 8]);
        end
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        wbuf_addr = a; wbuf_data = d; wbuf_we = 1'b1;
        @(negedge clk);
        wbuf_we = 1'b0;
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] wexp [5];
        int cnt;
        wexp[0] = 8'h11; wexp[1] = 8'h22; wexp[2] = 8'h33; wexp[3] = 8'h44; wexp[4] = 8'h00;

        rst = 1'b1; cmd_rd = 0; cmd_wr = 0; lba_i = '0; rbuf_addr = '0;
        wbuf_addr = '0; wbuf_data = '0; wbuf_we = 0; busy_i = 0; hndshk_i = 0; data_i = '0;
        @(negedge clk); @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_strobes", {rd_o, wr_o, hndshk_o}, 0);
        check("rst_data_o", data_o, 0);
        check("rst_addr_o", addr_o, 0);
        rst = 1'b0;

        // Full read
        issue("rd", 1'b1, 32'h10);
        busy_on("rd");
        send_byte("rd_b0", 8'hA1, got);
        send_byte("rd_b1", 8'hA2, got);
        send_byte("rd_b2", 8'hA3, got);
        send_byte("rd_b3", 8'hA4, got);
        finish_op("rd", 2, 2'd0);
        check_rbuf("rd", 32'hA4A3A2A1);

        // Full write, with a host write attempted mid-transfer
        host_wr(2'd0, 8'h11); host_wr(2'd1, 8'h22); host_wr(2'd2, 8'h33); host_wr(2'd3, 8'h44);
        issue("wr", 1'b0, 32'h20);
        busy_on("wr");
        send_byte("wr_b0", 8'h00, got);
        check("wr_data0", got, 8'h11);
        host_wr(2'd2, 8'hFF);
        for (int i = 1; i < 4; i++) begin
            send_byte($sformatf("wr_b%0d", i), 8'h00, got);
            check($sformatf("wr_data%0d", i), got, wexp[i]);
        end
        finish_op("wr", 2, 2'd0);

        // Start timeout
        issue("tmo", 1'b1, 32'h55);
        cnt = 0;
        while (rd_o && cnt < 100) begin cnt++; @(negedge clk); end
        check("tmo_rd_cycles", cnt, 20);
        finish_op("tmo", 1, 2'd1);
        check("tmo_rd_o", rd_o, 0);
        check_rbuf("tmo", 32'hA4A3A2A1);

        // Short block
        issue("short", 1'b1, 32'h66);
        busy_on("short");
        send_byte("short_b0", 8'hB1, got);
        send_byte("short_b1", 8'hB2, got);
        finish_op("short", 2, 2'd2);
        check_rbuf("short", 32'hA4A3B2B1);

        // Overlong read
        issue("longr", 1'b1, 32'h77);
        busy_on("longr");
        for (int i = 0; i < 5; i++)
            send_byte($sformatf("longr_b%0d", i), 8'hC1 + 8'(i), got);
        finish_op("longr", 2, 2'd3);
        check_rbuf("longr", 32'hC4C3C2C1);

        // Overlong write
        issue("longw", 1'b0, 32'h88);
        busy_on("longw");
        for (int i = 0; i < 5; i++) begin
            send_byte($sformatf("longw_b%0d", i), 8'h00, got);
            check($sformatf("longw_data%0d", i), got, wexp[i]);
        end
        finish_op("longw", 2, 2'd3);

        // Asynchronous reset while in HND
        issue("arst", 1'b1, 32'h30);
        busy_on("arst");
        data_i = 8'hE1; hndshk_i = 1'b1;
        @(negedge clk);
        check("arst_hs_before", hndshk_o, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_hs", hndshk_o, 0);
        check("arst_ready", ready, 1);
        check("arst_rd_o", rd_o, 0);
        check("arst_addr", addr_o, 0);
        hndshk_i = 1'b0; busy_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        issue("post", 1'b1, 32'h40);
        busy_on("post");
        send_byte("post_b0", 8'hD1, got);
        send_byte("post_b1", 8'hD2, got);
        send_byte("post_b2", 8'hD3, got);
        send_byte("post_b3", 8'hD4, got);
        finish_op("post", 2, 2'd0);
        check_rbuf("post", 32'hD4D3D2D1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
